alu_arb: RTL and testbench

Round-robin arbiter that shares the single combinational ALU between multiple requesters (for example the EX stage and the multi-cycle/AMO sequencer) and returns each result through a one-entry registered response slot. It sits between the requesters and the ALU instance. It drives the ALU operands and opcode from the granted request and captures `alu_res` into the response register. One operation is accepted per cycle when the response slot is free or draining.

---
 rtl/alu_arb.sv | 106 ++++++++++
 tb/tb_alu_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arb.sv
// alu_arb: round-robin arbiter that shares one combinational ALU and returns results through a one-entry response slot
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_op/src0/src1     per-requester opcode (5b) and operands (32b), packed by index
//   alu_op/src0/src1     drive to the shared ALU from the granted requester (zero when idle)
//   alu_res              combinational ALU result, captured on accept
//   rsp_valid/rsp_ready  response slot handshake
//   rsp_id, rsp_res      owner index and registered result of the held response
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority
// (no rotating pointer); otherwise grants rotate round-robin.

module alu_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*5-1:0]    req_op,
    input  logic [NREQ*32-1:0]   req_src0,
    input  logic [NREQ*32-1:0]   req_src1,
    output logic [4:0]           alu_op,
    output logic [31:0]          alu_src0,
    output logic [31:0]          alu_src1,
    input  logic [31:0]          alu_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_res
);

    typedef enum logic {EMPTY, FULL} slot_t;

    slot_t          state, state_nxt;
    logic           can_issue;
    logic           gnt_any;
    logic [IDW-1:0] gnt_id;
    logic           drive;
    logic           accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IDW-1:0] ptr;
`endif

    // First valid requester, searching upward from the rotating pointer with wrap.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            if (!gnt_any && req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(k);
            end
`else
            if (!gnt_any && req_valid[(int'(ptr) + k) % NREQ]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'((int'(ptr) + k) % NREQ);
            end
`endif
        end
    end

    assign can_issue = (state == EMPTY) | rsp_ready;
    assign drive     = gnt_any & ~rst;
    assign accept    = can_issue & drive;
    assign req_ready = accept ? (NREQ'(1) << gnt_id) : '0;

    // The ALU sees the granted operation even under backpressure; the slot decides acceptance.
    assign alu_op   = drive ? req_op[5*gnt_id +: 5]     : '0;
    assign alu_src0 = drive ? req_src0[32*gnt_id +: 32] : '0;
    assign alu_src1 = drive ? req_src1[32*gnt_id +: 32] : '0;

    // An accept always (re)fills the slot, covering drain+accept in the same cycle.
    always_comb state_nxt = accept ? FULL : (rsp_ready ? EMPTY : state);

    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id  <= '0;
            rsp_res <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr     <= '0;
`endif
        end else if (accept) begin
            rsp_id  <= gnt_id;
            rsp_res <= alu_res;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr     <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`endif
        end
    end

    assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: self-checking bench for alu_arb with a behavioural ALU and a transaction-level model
module tb_alu_arb;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*5-1:0]    req_op;
    logic [NREQ*32-1:0]   req_src0;
    logic [NREQ*32-1:0]   req_src1;
    logic [4:0]           alu_op;
    logic [31:0]          alu_src0;
    logic [31:0]          alu_src1;
    logic [31:0]          alu_res;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_res;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the response slot contents and the next search start.
    logic           m_valid;
    logic [IDW-1:0] m_id;
    logic [31:0]    m_res;
    int             m_ptr;
    int             last_acc;

    alu_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src0(req_src0), .req_src1(req_src1),
        .alu_op(alu_op), .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tb_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'h00:   return a + b;
            5'h01:   return a - b;
            5'h02:   return a ^ b;
            5'h10:   return $signed(a) >>> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    always_comb alu_res = tb_alu(alu_op, alu_src0, alu_src1);

    function automatic int m_grant();
        int base;
`ifdef ALU_ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = m_ptr;
`endif
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (base + k) % NREQ;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] m_ready();
        int g;
        g = m_grant();
        if (rst || (m_valid && !rsp_ready) || g < 0) return '0;
        return NREQ'(1) << g;
    endfunction

    task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]          = 1'b1;
        req_op[5*i +: 5]      = op;
        req_src0[32*i +: 32]  = a;
        req_src1[32*i +: 32]  = b;
    endtask

    // Advance the model by one clock using the currently driven inputs, then step the DUT.
    task automatic cycle();
        int g;
        g = m_grant();
        last_acc = -1;
        if (rst) begin
            m_valid = 1'b0;
            m_id    = '0;
            m_res   = 32'h0;
            m_ptr   = 0;
        end else if ((!m_valid || rsp_ready) && g >= 0) begin
            m_res    = tb_alu(req_op[5*g +: 5], req_src0[32*g +: 32], req_src1[32*g +: 32]);
            m_id     = IDW'(g);
            m_valid  = 1'b1;
            m_ptr    = (g + 1) % NREQ;
            last_acc = g;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 5'h00, 32'd1, 32'd2);
        set_req(1, 5'h00, 32'd3, 32'd4);
        #1;
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        n_checks++; if (alu_op !== 5'h0 || alu_src0 !== 32'h0 || alu_src1 !== 32'h0) begin n_fail++; $display("FAIL reset_alu: got op=%h s0=%h s1=%h expected zeros", alu_op, alu_src0, alu_src1); end
        cycle();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_id !== 1'b0 || rsp_res !== 32'h0) begin n_fail++; $display("FAIL reset_rsp: got id=%h res=%h expected 0/0", rsp_id, rsp_res); end
        req_valid = '0;
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_single_add();
        set_req(0, 5'h00, 32'd3, 32'd4);
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_ready: got %b expected 01", req_ready); end
        n_checks++; if (alu_src0 !== 32'd3 || alu_src1 !== 32'd4) begin n_fail++; $display("FAIL add_alu_drive: got %h/%h expected 3/4", alu_src0, alu_src1); end
        cycle();
        req_valid = '0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 32'h7) begin n_fail++; $display("FAIL add_rsp: got v=%b id=%h res=%h expected 1/0/7", rsp_valid, rsp_id, rsp_res); end
        drain();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_sra();
        set_req(1, 5'h10, 32'h8000_0000, 32'd4);
        #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL sra_ready: got %b expected 10", req_ready); end
        cycle();
        req_valid = '0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_res !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_rsp: got v=%b id=%h res=%h expected 1/1/f8000000", rsp_valid, rsp_id, rsp_res); end
        drain();
    endtask

    task automatic test_contention();
        logic [IDW-1:0] exp_ids [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        set_req(0, 5'h00, 32'd100, 32'd1);
        set_req(1, 5'h01, 32'd100, 32'd1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            n_checks++; if (rsp_id !== exp_ids[c]) begin n_fail++; $display("FAIL contention_id[%0d]: got %h expected %h", c, rsp_id, exp_ids[c]); end
            n_checks++; if (rsp_res !== (exp_ids[c] == 1'b0 ? 32'd101 : 32'd99)) begin n_fail++; $display("FAIL contention_res[%0d]: got %0d expected %0d", c, rsp_res, exp_ids[c] == 1'b0 ? 101 : 99); end
        end
        drain();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(0, 5'h00, 32'd10, 32'd20);
        cycle();
        req_valid = '0;
        set_req(1, 5'h02, 32'h0000_F0F0, 32'h0000_0FF0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 00", c, req_ready); end
            cycle();
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 32'd30) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b id=%h res=%0d expected 1/0/30", c, rsp_valid, rsp_id, rsp_res); end
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 10", req_ready); end
        cycle();
        req_valid = '0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_res !== 32'h0000_FF00) begin n_fail++; $display("FAIL bp_new_rsp: got v=%b id=%h res=%h expected 1/1/ff00", rsp_valid, rsp_id, rsp_res); end
        drain();
    endtask

    task automatic test_reset_full();
        set_req(0, 5'h00, 32'd5, 32'd6);
        cycle();
        req_valid = '0;
        set_req(1, 5'h00, 32'd1, 32'd1);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_res !== 32'd11) begin n_fail++; $display("FAIL rstfull_pre: got v=%b res=%0d expected 1/11", rsp_valid, rsp_res); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_res !== 32'h0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL rstfull_clear: got v=%b id=%h res=%h expected 0/0/0", rsp_valid, rsp_id, rsp_res); end
        set_req(0, 5'h00, 32'd2, 32'd2);
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstfull_restart: got %b expected 01", req_ready); end
        cycle();
        n_checks++; if (rsp_id !== 1'b0 || rsp_res !== 32'd4) begin n_fail++; $display("FAIL rstfull_rsp: got id=%h res=%0d expected 0/4", rsp_id, rsp_res); end
        drain();
    endtask

    task automatic test_undef_op();
        set_req(0, 5'h1F, $urandom, $urandom);
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL undef_ready: got %b expected 01", req_ready); end
        cycle();
        req_valid = '0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_res !== 32'h0) begin n_fail++; $display("FAIL undef_rsp: got v=%b res=%h expected 1/0", rsp_valid, rsp_res); end
        drain();
    endtask

    task automatic test_random();
        logic [4:0] ops [6];
        logic [4:0] exp_op;
        int g;
        ops = '{5'h00, 5'h01, 5'h02, 5'h10, 5'h1F, 5'h07};
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && $urandom_range(1, 0) == 1)
                    set_req(i, ops[$urandom_range(5, 0)], $urandom, $urandom);
            rsp_ready = ($urandom_range(3, 0) != 0);
            rst = ($urandom_range(39, 0) == 0);
            #1;
            g = m_grant();
            exp_op = (rst || g < 0) ? 5'h0 : req_op[5*g +: 5];
            n_checks++; if (req_ready !== m_ready()) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, req_ready, m_ready()); end
            n_checks++; if (alu_op !== exp_op) begin n_fail++; $display("FAIL rand_alu_op[%0d]: got %h expected %h", n, alu_op, exp_op); end
            cycle();
            n_checks++; if (rsp_valid !== m_valid || rsp_id !== m_id || rsp_res !== m_res) begin n_fail++; $display("FAIL rand_rsp[%0d]: got v=%b id=%h res=%h expected %b/%h/%h", n, rsp_valid, rsp_id, rsp_res, m_valid, m_id, m_res); end
            if (last_acc >= 0) begin
                if ($urandom_range(1, 0) == 1)
                    req_valid[last_acc] = 1'b0;
                else
                    set_req(last_acc, ops[$urandom_range(5, 0)], $urandom, $urandom);
            end
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_src0  = '0;
        req_src1  = '0;
        rsp_ready = 1'b0;
        m_valid   = 1'b0;
        m_id      = '0;
        m_res     = 32'h0;
        m_ptr     = 0;
        last_acc  = -1;
        test_reset();
        test_single_add();
        test_sra();
        test_contention();
        test_backpressure();
        test_reset_full();
        test_undef_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
